// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding for the bit-serial arithmetic blocks.
package serial_arith_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit full subtractor, d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with valid/ready handshakes.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    sub_state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0] cnt;
    logic borrow, sa, sb, d, borrow_nx, last;
    full_subtractor u_fs (
        .a(a_sh[0]),
        .b(b_sh[0]),
        .bin(borrow),
        .d(d),
        .bout(borrow_nx)
    );
    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_nx = state;
        if (state == IDLE && in_valid) state_nx = RUN;
        else if (state == RUN && last) state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            sa     <= a[WIDTH-1];
            sb     <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            borrow <= borrow_nx;
            // result bit enters at the MSB so the word is aligned after WIDTH shifts
            diff   <= WIDTH'({d, diff} >> 1);
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout <= borrow_nx;
                ovf  <= (sa != sb) && (d != sa);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 1, 8 and 13.
module tb_serial_subtractor;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, bin = 0;
    logic [12:0] a = '0, b = '0;
    logic ir8, ov8, bo8, of8, ir1, ov1, bo1, of1, ir13, ov13, bo13, of13;
    logic [7:0] d8;
    logic [0:0] d1;
    logic [12:0] d13;
    int tests = 0, fails = 0, lat8 = 0;
    logic timeout = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .bin(bin), .out_valid(ov8), .out_ready(out_ready),
        .diff(d8), .bout(bo8), .ovf(of8));
    serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a[0:0]), .b(b[0:0]), .bin(bin), .out_valid(ov1), .out_ready(out_ready),
        .diff(d1), .bout(bo1), .ovf(of1));
    serial_subtractor #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir13),
        .a(a), .b(b), .bin(bin), .out_valid(ov13), .out_ready(out_ready),
        .diff(d13), .bout(bo13), .ovf(of13));

    // Present operands for one accept edge, then wait (bounded) until all three results are valid.
    task automatic op(input logic [12:0] ta, input logic [12:0] tb, input logic tbin);
        a = ta; b = tb; bin = tbin; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; lat8 = 0;
        for (int i = 1; i <= 40 && !(ov8 && ov1 && ov13); i++) begin
            @(posedge clk); #1;
            if (ov8 && lat8 == 0) lat8 = i;
        end
        timeout = !(ov8 && ov1 && ov13);
    endtask

    task automatic take;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1;
        tests++;
        if ({ir8, ov8, d8, bo8, of8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: ir=%b ov=%b diff=%h bout=%b ovf=%b, required 1 0 00 0 0", ir8, ov8, d8, bo8, of8);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        logic [7:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00};
        logic [7:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00};
        logic       vi [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ed [5] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hFF};
        logic       eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            op({5'h0, va[k]}, {5'h0, vb[k]}, vi[k]);
            tests++;
            if (timeout || lat8 !== 8) begin
                fails++;
                $display("FAIL latency[%0d]: timeout=%b cycles=%0d, required 8", k, timeout, lat8);
            end
            tests++;
            if ({d8, bo8, of8} !== {ed[k], eb[k], eo[k]}) begin
                fails++;
                $display("FAIL vector[%0d] %h-%h-%b: diff=%h bout=%b ovf=%b, required %h %b %b",
                         k, va[k], vb[k], vi[k], d8, bo8, of8, ed[k], eb[k], eo[k]);
            end
            take();
        end
    endtask

    task automatic test_back_to_back;
        op(13'h05, 13'h03, 0);
        for (int i = 0; i < 5; i++) begin
            a = 13'h0AA; b = 13'h011; in_valid = i[0];
            @(posedge clk); #1;
            tests++;
            if ({ov8, ir8, d8, bo8, of8} !== {1'b1, 1'b0, 8'h02, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL hold[%0d]: ov=%b ir=%b diff=%h bout=%b ovf=%b, required 1 0 02 0 0",
                         i, ov8, ir8, d8, bo8, of8);
            end
        end
        in_valid = 0;
        take();
        tests++;
        if ({ir8, ov8} !== 2'b10) begin
            fails++;
            $display("FAIL release: ir=%b ov=%b, required 1 0", ir8, ov8);
        end
    endtask

    task automatic test_reset_mid;
        a = 13'h55; b = 13'h22; bin = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        tests++;
        if ({ir8, ov8, d8, bo8, of8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: ir=%b ov=%b diff=%h bout=%b ovf=%b, required 1 0 00 0 0", ir8, ov8, d8, bo8, of8);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        op(13'h10, 13'h01, 0);
        tests++;
        if (timeout || {d8, bo8, of8} !== {8'h0F, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL after_reset: timeout=%b diff=%h bout=%b ovf=%b, required 0 0f 0 0", timeout, d8, bo8, of8);
        end
        take();
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true signed range.
    task automatic expect_w(input int w, input int ua, input int ub, input int ib,
                            output int ed, output logic eb, output logic eo);
        int half, sa, sb, r;
        half = 1 << (w - 1);
        ed = (ua - ub - ib) & ((1 << w) - 1);
        eb = ua < ub + ib;
        sa = ua >= half ? ua - (1 << w) : ua;
        sb = ub >= half ? ub - (1 << w) : ub;
        r = sa - sb - ib;
        eo = r < -half || r > half - 1;
    endtask

    task automatic test_random;
        int ed;
        logic eb, eo;
        logic [12:0] ra, rb;
        logic ri;
        for (int n = 0; n < 334; n++) begin
            ra = 13'($urandom); rb = 13'($urandom); ri = 1'($urandom);
            op(ra, rb, ri);
            tests++;
            if (timeout) begin
                fails++;
                $display("FAIL rnd_timeout[%0d]: out_valid 8/1/13 = %b%b%b, required 111", n, ov8, ov1, ov13);
            end
            expect_w(8, int'(ra[7:0]), int'(rb[7:0]), int'(ri), ed, eb, eo);
            tests++;
            if ({d8, bo8, of8} !== {ed[7:0], eb, eo}) begin
                fails++;
                $display("FAIL rnd8 %h-%h-%b: %h %b %b, required %h %b %b", ra[7:0], rb[7:0], ri, d8, bo8, of8, ed[7:0], eb, eo);
            end
            expect_w(1, int'(ra[0]), int'(rb[0]), int'(ri), ed, eb, eo);
            tests++;
            if ({d1, bo1, of1} !== {ed[0], eb, eo}) begin
                fails++;
                $display("FAIL rnd1 %b-%b-%b: %b %b %b, required %b %b %b", ra[0], rb[0], ri, d1, bo1, of1, ed[0], eb, eo);
            end
            expect_w(13, int'(ra), int'(rb), int'(ri), ed, eb, eo);
            tests++;
            if ({d13, bo13, of13} !== {ed[12:0], eb, eo}) begin
                fails++;
                $display("FAIL rnd13 %h-%h-%b: %h %b %b, required %h %b %b", ra, rb, ri, d13, bo13, of13, ed[12:0], eb, eo);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
